// File: rtl/rs_station.sv
// Reservation station for one execution unit: holds dispatched ops until both operands are valid and issues the oldest ready one.
// Optional macro RS_BYPASS_EN lets a ready dispatch go straight to the issue register when no stored entry is ready.
module rs_station #(
    parameter int ENTRIES   = 4,
    parameter int UNIT_ID   = 0,
    parameter int EX_UNIT_W = 3,
    parameter int OP_W      = 6,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [EX_UNIT_W-1:0] in_ex_unit,
    input  logic [OP_W-1:0]      in_op,
    input  logic [TAG_W-1:0]     in_tag1,
    input  logic [TAG_W-1:0]     in_tag2,
    input  logic [DATA_W-1:0]    in_val1,
    input  logic [DATA_W-1:0]    in_val2,
    input  logic [TAG_W-1:0]     in_target,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    output logic                 full,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [DATA_W-1:0]    out_val1,
    output logic [DATA_W-1:0]    out_val2,
    output logic [TAG_W-1:0]     out_target
);

    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;
    localparam logic [TAG_W-1:0]  NO_TAG    = {TAG_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [OP_W-1:0]   ZERO_OP   = {OP_W{1'b0}};

    // Age is the number of older valid entries: 0 is the oldest, ages stay unique and dense.
    logic              valid_r  [ENTRIES];
    logic [OP_W-1:0]   op_r     [ENTRIES];
    logic [TAG_W-1:0]  tag1_r   [ENTRIES];
    logic [TAG_W-1:0]  tag2_r   [ENTRIES];
    logic [DATA_W-1:0] val1_r   [ENTRIES];
    logic [DATA_W-1:0] val2_r   [ENTRIES];
    logic [TAG_W-1:0]  target_r [ENTRIES];
    logic [AW-1:0]     age_r    [ENTRIES];
    logic [CW-1:0]     count_r;

    logic [TAG_W-1:0]  d_tag1_s;
    logic [TAG_W-1:0]  d_tag2_s;
    logic [DATA_W-1:0] d_val1_s;
    logic [DATA_W-1:0] d_val2_s;
    logic              sel_found_s;
    logic [AW-1:0]     sel_idx_s;
    logic [AW-1:0]     sel_age_s;
    logic [AW-1:0]     free_idx_s;
    logic [AW-1:0]     new_age_s;
    logic              load_s;
    logic              acc_s;
    logic              issue_s;
    logic              byp_s;
    logic              write_s;

    assign full      = (count_r == CW'(ENTRIES));
    assign load_s    = !out_valid || out_ready;
    assign acc_s     = (in_target != NO_TAG) && (in_ex_unit == EX_UNIT_W'(UNIT_ID)) && !full;
    assign issue_s   = load_s && sel_found_s;
    assign write_s   = acc_s && !byp_s;
    assign new_age_s = AW'(count_r - {{(CW-1){1'b0}}, issue_s});

`ifdef RS_BYPASS_EN
    assign byp_s = acc_s && load_s && !sel_found_s && (d_tag1_s == NO_TAG) && (d_tag2_s == NO_TAG);
`else
    assign byp_s = 1'b0;
`endif

    // Capture a result broadcast in the same cycle as the dispatch of its consumer.
    always_comb begin
        d_tag1_s = in_tag1;
        d_val1_s = in_val1;
        d_tag2_s = in_tag2;
        d_val2_s = in_val2;
        if ((in_tag1 != NO_TAG) && (in_tag1 == cdb_tag)) begin
            d_tag1_s = NO_TAG;
            d_val1_s = cdb_data;
        end else begin
            d_tag1_s = in_tag1;
            d_val1_s = in_val1;
        end
        if ((in_tag2 != NO_TAG) && (in_tag2 == cdb_tag)) begin
            d_tag2_s = NO_TAG;
            d_val2_s = cdb_data;
        end else begin
            d_tag2_s = in_tag2;
            d_val2_s = in_val2;
        end
    end

    // Pick the oldest ready entry and the lowest-indexed free slot.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {AW{1'b0}};
        sel_age_s   = {AW{1'b0}};
        free_idx_s  = {AW{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_r[i] && (tag1_r[i] == NO_TAG) && (tag2_r[i] == NO_TAG) &&
                (!sel_found_s || (age_r[i] < sel_age_s))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = AW'(i);
                sel_age_s   = age_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = AW'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Slot storage: free on issue, fill on dispatch, wake up on result broadcast, compact ages.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                op_r[i]     <= ZERO_OP;
                tag1_r[i]   <= NO_TAG;
                tag2_r[i]   <= NO_TAG;
                val1_r[i]   <= ZERO_DATA;
                val2_r[i]   <= ZERO_DATA;
                target_r[i] <= NO_TAG;
                age_r[i]    <= {AW{1'b0}};
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (issue_s && (sel_idx_s == AW'(i))) begin
                    valid_r[i] <= 1'b0;
                end else if (write_s && (free_idx_s == AW'(i))) begin
                    valid_r[i]  <= 1'b1;
                    op_r[i]     <= in_op;
                    tag1_r[i]   <= d_tag1_s;
                    tag2_r[i]   <= d_tag2_s;
                    val1_r[i]   <= d_val1_s;
                    val2_r[i]   <= d_val2_s;
                    target_r[i] <= in_target;
                    age_r[i]    <= new_age_s;
                end else if (valid_r[i]) begin
                    if ((cdb_tag != NO_TAG) && (tag1_r[i] == cdb_tag)) begin
                        tag1_r[i] <= NO_TAG;
                        val1_r[i] <= cdb_data;
                    end
                    if ((cdb_tag != NO_TAG) && (tag2_r[i] == cdb_tag)) begin
                        tag2_r[i] <= NO_TAG;
                        val2_r[i] <= cdb_data;
                    end
                    if (issue_s && (age_r[i] > sel_age_s)) begin
                        age_r[i] <= age_r[i] - AW'(1);
                    end
                end
            end
        end
    end

    // Occupancy counter driving full.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_r <= {CW{1'b0}};
        end else if (write_s && !issue_s) begin
            count_r <= count_r + CW'(1);
        end else if (!write_s && issue_s) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Issue register; fields hold while stalled by out_ready.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid  <= 1'b0;
            out_op     <= ZERO_OP;
            out_val1   <= ZERO_DATA;
            out_val2   <= ZERO_DATA;
            out_target <= NO_TAG;
        end else if (issue_s) begin
            out_valid  <= 1'b1;
            out_op     <= op_r[sel_idx_s];
            out_val1   <= val1_r[sel_idx_s];
            out_val2   <= val2_r[sel_idx_s];
            out_target <= target_r[sel_idx_s];
        end else if (byp_s) begin
            out_valid  <= 1'b1;
            out_op     <= in_op;
            out_val1   <= d_val1_s;
            out_val2   <= d_val2_s;
            out_target <= in_target;
        end else if (load_s) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus random traffic against an age-ordered queue model.
module tb_rs_station;

    localparam int ENTRIES   = 4;
    localparam int UNIT_ID   = 0;
    localparam int EX_UNIT_W = 3;
    localparam int OP_W      = 6;
    localparam int TAG_W     = 4;
    localparam int DATA_W    = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [EX_UNIT_W-1:0] in_ex_unit;
    logic [OP_W-1:0]      in_op;
    logic [TAG_W-1:0]     in_tag1;
    logic [TAG_W-1:0]     in_tag2;
    logic [DATA_W-1:0]    in_val1;
    logic [DATA_W-1:0]    in_val2;
    logic [TAG_W-1:0]     in_target;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 full;
    logic                 out_valid;
    logic                 out_ready;
    logic [OP_W-1:0]      out_op;
    logic [DATA_W-1:0]    out_val1;
    logic [DATA_W-1:0]    out_val2;
    logic [TAG_W-1:0]     out_target;

    rs_station #(
        .ENTRIES(ENTRIES), .UNIT_ID(UNIT_ID), .EX_UNIT_W(EX_UNIT_W),
        .OP_W(OP_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_ex_unit(in_ex_unit), .in_op(in_op),
        .in_tag1(in_tag1), .in_tag2(in_tag2),
        .in_val1(in_val1), .in_val2(in_val2),
        .in_target(in_target), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .full(full), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_val1(out_val1), .out_val2(out_val2),
        .out_target(out_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  t1;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [TAG_W-1:0]  tgt;
    } ent_t;

    ent_t q[$];           // waiting instructions, oldest first
    ent_t m_out;
    logic m_valid;
    int   checks   = 0;
    int   failures = 0;
    logic [TAG_W-1:0] got_tgt[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check_eq("full", 64'(full), 64'(q.size() == ENTRIES));
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_op", 64'(out_op), 64'(m_out.op));
            check_eq("out_val1", 64'(out_val1), 64'(m_out.v1));
            check_eq("out_val2", 64'(out_val2), 64'(m_out.v2));
            check_eq("out_target", 64'(out_target), 64'(m_out.tgt));
        end
    endtask

    // Reference behaviour for one rising edge, from the current inputs.
    task automatic model_edge();
        ent_t n;
        int   idx;
        logic acc;
        logic load;
        logic byp;
        if (rst || flush) begin
            q.delete();
            m_valid = 1'b0;
            return;
        end
        acc  = (in_target != 0) && (in_ex_unit == EX_UNIT_W'(UNIT_ID)) && (q.size() < ENTRIES);
        load = !m_valid || out_ready;
        n.op  = in_op;
        n.tgt = in_target;
        n.t1  = (in_tag1 != 0 && in_tag1 == cdb_tag) ? TAG_W'(0) : in_tag1;
        n.v1  = (in_tag1 != 0 && in_tag1 == cdb_tag) ? cdb_data : in_val1;
        n.t2  = (in_tag2 != 0 && in_tag2 == cdb_tag) ? TAG_W'(0) : in_tag2;
        n.v2  = (in_tag2 != 0 && in_tag2 == cdb_tag) ? cdb_data : in_val2;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && q[i].t1 == 0 && q[i].t2 == 0) idx = i;
        end
        byp = 1'b0;
        if (load) begin
            if (idx >= 0) begin
                m_out   = q[idx];
                m_valid = 1'b1;
                q.delete(idx);
            end else begin
`ifdef RS_BYPASS_EN
                if (acc && n.t1 == 0 && n.t2 == 0) begin
                    m_out   = n;
                    m_valid = 1'b1;
                    byp     = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
`else
                m_valid = 1'b0;
`endif
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            if (cdb_tag != 0 && q[i].t1 == cdb_tag) begin q[i].t1 = 0; q[i].v1 = cdb_data; end
            if (cdb_tag != 0 && q[i].t2 == cdb_tag) begin q[i].t2 = 0; q[i].v2 = cdb_data; end
        end
        if (acc && !byp) q.push_back(n);
    endtask

    task automatic step();
        compare_outputs();
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_idle();
        in_target = '0;
        in_tag1   = '0;
        in_tag2   = '0;
        cdb_tag   = '0;
        flush     = 1'b0;
    endtask

    task automatic disp(input int op, input int t1, input int t2, input int v1, input int v2, input int tgt);
        in_ex_unit = EX_UNIT_W'(UNIT_ID);
        in_op      = OP_W'(op);
        in_tag1    = TAG_W'(t1);
        in_tag2    = TAG_W'(t2);
        in_val1    = DATA_W'(v1);
        in_val2    = DATA_W'(v2);
        in_target  = TAG_W'(tgt);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_ex_unit = '0; in_op = '0; in_tag1 = '0; in_tag2 = '0;
        in_val1 = '0; in_val2 = '0; in_target = '0; cdb_tag = '0; cdb_data = '0;
        m_valid = 1'b0;
        m_out = '{op: '0, t1: '0, t2: '0, v1: '0, v2: '0, tgt: '0};
        repeat (2) @(negedge clk);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_op", 64'(out_op), 64'd0);
        check_eq("rst_out_val1", 64'(out_val1), 64'd0);
        check_eq("rst_out_target", 64'(out_target), 64'd0);
        rst = 1'b0;
        step();

        // Basic latency
        disp(5, 0, 0, 10, 20, 3);
        step();
        set_idle();
`ifndef RS_BYPASS_EN
        check_eq("lat_early", 64'(out_valid), 64'd0);
        step();
`endif
        check_eq("lat_valid", 64'(out_valid), 64'd1);
        check_eq("lat_op", 64'(out_op), 64'd5);
        check_eq("lat_val1", 64'(out_val1), 64'd10);
        check_eq("lat_val2", 64'(out_val2), 64'd20);
        check_eq("lat_target", 64'(out_target), 64'd3);
        repeat (3) step();

        // Wakeup by broadcast
        disp(1, 7, 0, 0, 2, 4);
        step();
        set_idle();
        repeat (2) step();
        cdb_tag = 4'd7; cdb_data = 32'h55;
        step();
        cdb_tag = 4'd0;
        repeat (3) step();

        // Wrong tag never wakes
        disp(1, 7, 0, 0, 2, 4);
        step();
        set_idle();
        repeat (2) step();
        cdb_tag = 4'd6; cdb_data = 32'h66;
        step();
        cdb_tag = 4'd0;
        repeat (4) step();
        check_eq("no_wake_valid", 64'(out_valid), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Same-cycle capture
        disp(2, 0, 9, 1, 0, 6);
        cdb_tag = 4'd9; cdb_data = 32'hAA;
        step();
        set_idle();
        repeat (4) step();

        // Fill under backpressure, then drain in order
        out_ready = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            disp(t + 8, 0, 0, t * 3, t * 5, t);
            step();
        end
        check_eq("fill_full", 64'(full), 64'd1);
        disp(14, 0, 0, 1, 1, 6);
        step();
        set_idle();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) got_tgt.push_back(out_target);
            step();
        end
        check_eq("drain_count", 64'(got_tgt.size()), 64'd5);
        for (int k = 0; k < got_tgt.size(); k++) check_eq("drain_order", 64'(got_tgt[k]), 64'(k + 1));

        // Younger ready entry passes an older waiting one
        disp(20, 3, 0, 0, 7, 7);
        step();
        disp(21, 0, 0, 8, 9, 8);
        step();
        set_idle();
        repeat (3) step();
        cdb_tag = 4'd3; cdb_data = 32'h33;
        step();
        cdb_tag = 4'd0;
        repeat (3) step();

        // Flush with a same-cycle dispatch
        out_ready = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            disp(t, 0, 0, t, t, t + 10);
            step();
        end
        disp(30, 0, 0, 5, 5, 15);
        flush = 1'b1;
        step();
        set_idle();
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_full", 64'(full), 64'd0);
        out_ready = 1'b1;
        repeat (4) step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            in_ex_unit = ($urandom_range(3) == 0) ? EX_UNIT_W'($urandom_range(7)) : EX_UNIT_W'(UNIT_ID);
            in_op      = OP_W'($urandom);
            in_tag1    = ($urandom_range(1) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(7));
            in_tag2    = ($urandom_range(1) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(7));
            in_val1    = DATA_W'($urandom);
            in_val2    = DATA_W'($urandom);
            in_target  = TAG_W'($urandom_range(15));
            cdb_tag    = ($urandom_range(2) == 0) ? TAG_W'(0) : TAG_W'($urandom_range(7));
            cdb_data   = DATA_W'($urandom);
            out_ready  = ($urandom_range(3) != 0);
            flush      = ($urandom_range(99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
